if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: the producer side of the IF->ID interface and of the br_bus loop.

---
 rtl/if_fetch_unit_pkg.sv | 27 ++
 rtl/if_inst_hold.sv | 40 ++++
 rtl/if_fetch_unit.sv | 82 ++++++++
 tb/tb_if_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, stall encodings and hold-FSM states for the instruction-fetch stage.
// The bus width depends on IF_ALIGN_CHECK_EN, which adds the adel flag to the IF->ID bus.
package if_fetch_unit_pkg;

   localparam int STALL_W = 2;
   localparam logic STOP = 1'b1;
   localparam logic NO_STOP = 1'b0;
   localparam int BR_WD = 33;

`ifdef IF_ALIGN_CHECK_EN
   localparam int IF_TO_ID_WD = 34;
`else
   localparam int IF_TO_ID_WD = 33;
`endif

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFBF_FFFC;

   typedef enum logic {
      HOLD_RUN  = 1'b0,
      HOLD_HOLD = 1'b1
   } hold_state_e;

   function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_inst_hold.sv
// RUN/HOLD instruction buffer: captures the SRAM word when IF/ID stalls so it is never lost.
module if_inst_hold
   import if_fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] inst_o
);

   hold_state_e state_q;
   logic [31:0] hold_q;

   // Capture on stall entry; the held word stays visible through the release cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HOLD_RUN;
         hold_q  <= 32'b0;
      end else begin
         case (state_q)
            HOLD_RUN: begin
               if (stall_i == STOP) begin
                  hold_q  <= rdata_i;
                  state_q <= HOLD_HOLD;
               end
            end
            HOLD_HOLD: begin
               if (stall_i != STOP) begin
                  state_q <= HOLD_RUN;
               end
            end
            default: state_q <= HOLD_RUN;
         endcase
      end
   end

   assign inst_o = (state_q == HOLD_HOLD) ? hold_q : rdata_i;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and replays stalled redirects.
// Define IF_ALIGN_CHECK_EN to flag misaligned PCs (adel) and suppress their fetches.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STALL_W-1:0]     stall,
   input  logic [BR_WD-1:0]       br_bus,
   input  logic [31:0]            inst_sram_rdata,
   output logic                   inst_sram_en,
   output logic [3:0]             inst_sram_wen,
   output logic [31:0]            inst_sram_addr,
   output logic [31:0]            inst_sram_wdata,
   output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
   output logic [31:0]            id_inst
);

   logic        brE;
   logic [31:0] brAddr;
   logic [31:0] pc_q, pc_d;
   logic        ce_q;
   logic        brPend_q;
   logic [31:0] brPendAddr_q;
   logic [31:0] heldInst;

   assign brE    = br_bus[32];
   assign brAddr = br_bus[31:0];

   // A live redirect always beats a replayed one.
   always_comb begin
      pc_d = pcPlus4(pc_q);
      if (brE) begin
         pc_d = brAddr;
      end else if (brPend_q) begin
         pc_d = brPendAddr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         ce_q         <= 1'b0;
         brPend_q     <= 1'b0;
         brPendAddr_q <= 32'b0;
      end else if (stall[0] != STOP) begin
         pc_q     <= pc_d;
         ce_q     <= 1'b1;
         brPend_q <= 1'b0;
      end else if (brE) begin
         brPend_q     <= 1'b1;
         brPendAddr_q <= brAddr;
      end
   end

   if_inst_hold u_inst_hold (
      .clk     (clk),
      .rst     (rst),
      .stall_i (stall[1]),
      .rdata_i (inst_sram_rdata),
      .inst_o  (heldInst)
   );

   assign inst_sram_wen   = 4'b0;
   assign inst_sram_wdata = 32'b0;
   assign inst_sram_addr  = pc_q;

`ifdef IF_ALIGN_CHECK_EN
   logic adel;
   assign adel         = |pc_q[1:0];
   assign inst_sram_en = ce_q & ~adel;
   assign if_to_id_bus = {adel, ce_q, pc_q};
   assign id_inst      = adel ? 32'b0 : heldInst;
`else
   assign inst_sram_en = ce_q;
   assign if_to_id_bus = {ce_q, pc_q};
   assign id_inst      = heldInst;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written corner sequence and randomized run
// against a reference model of the fetch rules.
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   logic                   clk;
   logic                   rst;
   logic [STALL_W-1:0]     stall;
   logic [BR_WD-1:0]       br_bus;
   logic [31:0]            inst_sram_rdata;
   logic                   inst_sram_en;
   logic [3:0]             inst_sram_wen;
   logic [31:0]            inst_sram_addr;
   logic [31:0]            inst_sram_wdata;
   logic [IF_TO_ID_WD-1:0] if_to_id_bus;
   logic [31:0]            id_inst;

   int vectors;
   int miscompares;

   if_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .br_bus          (br_bus),
      .inst_sram_rdata (inst_sram_rdata),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .if_to_id_bus    (if_to_id_bus),
      .id_inst         (id_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  stall;
      logic        brE;
      logic [31:0] brAddr;
      logic [31:0] rdata;
      logic [31:0] expAddr;
      logic        expCe;
      logic [31:0] expInst;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs[NVEC];

   function automatic vec_t mkVec(input logic r, input logic [1:0] s, input logic b,
                                  input logic [31:0] ba, input logic [31:0] rd,
                                  input logic [31:0] ea, input logic ec, input logic [31:0] ei);
      vec_t v;
      v.rst = r; v.stall = s; v.brE = b; v.brAddr = ba; v.rdata = rd;
      v.expAddr = ea; v.expCe = ec; v.expInst = ei;
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic [1:0] s, input logic b,
                                input logic [31:0] ba, input logic [31:0] rd);
      rst             = r;
      stall           = s;
      br_bus          = {b, ba};
      inst_sram_rdata = rd;
   endtask

   // Expected enable/bus/instruction follow from the PC, ce and the alignment rule.
   task automatic checkOutput(input string name, input logic [31:0] expAddr,
                              input logic expCe, input logic [31:0] expInstIn);
      logic                   expEn;
      logic [31:0]            expInst;
      logic [IF_TO_ID_WD-1:0] expBus;
      expEn   = expCe;
      expInst = expInstIn;
`ifdef IF_ALIGN_CHECK_EN
      if (expAddr[1:0] != 2'b00) begin
         expEn   = 1'b0;
         expInst = 32'b0;
      end
      expBus = {(expAddr[1:0] != 2'b00), expCe, expAddr};
`else
      expBus = {expCe, expAddr};
`endif
      vectors++;
      if (inst_sram_addr !== expAddr || inst_sram_en !== expEn || if_to_id_bus !== expBus ||
          id_inst !== expInst || inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin
         miscompares++;
         $display("[TB] FAIL %s: got addr=%h en=%b bus=%h inst=%h wen=%h wdata=%h, want addr=%h en=%b bus=%h inst=%h wen=0 wdata=0",
                  name, inst_sram_addr, inst_sram_en, if_to_id_bus, id_inst, inst_sram_wen,
                  inst_sram_wdata, expAddr, expEn, expBus, expInst);
      end
   endtask

   // Reference model state: architectural PC, fetch-valid, pending redirect, held word.
   logic [31:0] mPc;
   logic        mCe;
   logic        mPend;
   logic [31:0] mPendAddr;
   logic        mHolding;
   logic [31:0] mHeld;

   task automatic modelStep(input logic r, input logic [1:0] s, input logic b,
                            input logic [31:0] ba, input logic [31:0] rd);
      if (r) begin
         mPc = 32'hBFBF_FFFC; mCe = 1'b0; mPend = 1'b0; mPendAddr = 32'b0;
         mHolding = 1'b0; mHeld = 32'b0;
      end else begin
         if (!s[0]) begin
            if (b)          mPc = ba;
            else if (mPend) mPc = mPendAddr;
            else            mPc = mPc + 32'd4;
            mCe   = 1'b1;
            mPend = 1'b0;
         end else if (b) begin
            mPend     = 1'b1;
            mPendAddr = ba;
         end
         if (!mHolding && s[1]) begin
            mHolding = 1'b1;
            mHeld    = rd;
         end else if (mHolding && !s[1]) begin
            mHolding = 1'b0;
         end
      end
   endtask

   initial begin
      logic [31:0] rnd;
      logic        rRst;
      logic [1:0]  rStall;
      logic        rBr;
      logic [31:0] rAddr;
      logic [31:0] rData;

      vectors     = 0;
      miscompares = 0;

      vecs[0]  = mkVec(1, 2'b00, 0, 32'h0,          32'h0,          32'hBFBF_FFFC, 0, 32'h0);
      vecs[1]  = mkVec(1, 2'b00, 0, 32'h0,          32'h0,          32'hBFBF_FFFC, 0, 32'h0);
      vecs[2]  = mkVec(0, 2'b00, 0, 32'h0,          32'h0,          32'hBFBF_FFFC, 0, 32'h0);
      vecs[3]  = mkVec(0, 2'b00, 0, 32'h0,          32'h1111_1111, 32'hBFC0_0000, 1, 32'h1111_1111);
      vecs[4]  = mkVec(0, 2'b00, 0, 32'h0,          32'h2222_2222, 32'hBFC0_0004, 1, 32'h2222_2222);
      vecs[5]  = mkVec(0, 2'b00, 1, 32'hBFC0_0100, 32'h3C01_1234, 32'hBFC0_0008, 1, 32'h3C01_1234);
      vecs[6]  = mkVec(0, 2'b11, 0, 32'h0,          32'h3C01_1234, 32'hBFC0_0100, 1, 32'h3C01_1234);
      vecs[7]  = mkVec(0, 2'b11, 1, 32'hBFC0_0200, 32'hDEAD_BEEF, 32'hBFC0_0100, 1, 32'h3C01_1234);
      vecs[8]  = mkVec(0, 2'b11, 0, 32'h0,          32'hDEAD_BEEF, 32'hBFC0_0100, 1, 32'h3C01_1234);
      vecs[9]  = mkVec(0, 2'b00, 0, 32'h0,          32'hDEAD_BEEF, 32'hBFC0_0100, 1, 32'h3C01_1234);
      vecs[10] = mkVec(0, 2'b00, 0, 32'h0,          32'hDEAD_BEEF, 32'hBFC0_0200, 1, 32'hDEAD_BEEF);
      vecs[11] = mkVec(0, 2'b01, 1, 32'hBFC0_0300, 32'h0000_0055, 32'hBFC0_0204, 1, 32'h0000_0055);
      vecs[12] = mkVec(1, 2'b00, 0, 32'h0,          32'h0000_0066, 32'hBFC0_0204, 1, 32'h0000_0066);
      vecs[13] = mkVec(0, 2'b00, 0, 32'h0,          32'h0000_0077, 32'hBFBF_FFFC, 0, 32'h0000_0077);
      vecs[14] = mkVec(0, 2'b00, 0, 32'h0,          32'h0000_0088, 32'hBFC0_0000, 1, 32'h0000_0088);
      vecs[15] = mkVec(0, 2'b01, 1, 32'hBFC0_0400, 32'h0000_0099, 32'hBFC0_0004, 1, 32'h0000_0099);
      vecs[16] = mkVec(0, 2'b00, 1, 32'hBFC0_0500, 32'h0000_00AA, 32'hBFC0_0004, 1, 32'h0000_00AA);
      vecs[17] = mkVec(0, 2'b00, 0, 32'h0,          32'h0000_00BB, 32'hBFC0_0500, 1, 32'h0000_00BB);
      vecs[18] = mkVec(0, 2'b00, 1, 32'hFFFF_FFFC, 32'h0000_00CC, 32'hBFC0_0504, 1, 32'h0000_00CC);
      vecs[19] = mkVec(0, 2'b00, 0, 32'h0,          32'h0000_00DD, 32'hFFFF_FFFC, 1, 32'h0000_00DD);
      vecs[20] = mkVec(0, 2'b00, 0, 32'h0,          32'h0000_00EE, 32'h0000_0000, 1, 32'h0000_00EE);

      applyStimulus(1, 2'b00, 0, 32'h0, 32'h0);
      @(posedge clk);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].brE, vecs[i].brAddr, vecs[i].rdata);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expCe, vecs[i].expInst);
      end

      // Redirect to a misaligned target; alignment flagging applies only when enabled.
      @(negedge clk);
      applyStimulus(1, 2'b00, 0, 32'h0, 32'h0);
      @(negedge clk);
      applyStimulus(0, 2'b00, 1, 32'hBFC0_0102, 32'h0000_AAAA);
      #1;
      checkOutput("misalignPre", 32'hBFBF_FFFC, 1'b0, 32'h0000_AAAA);
      @(negedge clk);
      applyStimulus(0, 2'b00, 0, 32'h0, 32'h0000_1234);
      #1;
      checkOutput("misalignTarget", 32'hBFC0_0102, 1'b1, 32'h0000_1234);
      @(negedge clk);
      applyStimulus(0, 2'b00, 0, 32'h0, 32'h0000_5678);
      #1;
      checkOutput("misalignNext", 32'hBFC0_0106, 1'b1, 32'h0000_5678);

      @(negedge clk);
      applyStimulus(1, 2'b00, 0, 32'h0, 32'h0);
      @(posedge clk);
      modelStep(1, 2'b00, 0, 32'h0, 32'h0);

      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         rnd    = $urandom;
         rRst   = (rnd[5:0] == 6'd0);
         rStall = rnd[7] ? 2'b00 : rnd[9:8];
         rBr    = (rnd[11:10] == 2'b00);
         rnd    = $urandom;
         rAddr  = {rnd[31:2], 2'b00};
         rData  = $urandom;
         applyStimulus(rRst, rStall, rBr, rAddr, rData);
         #1;
         checkOutput($sformatf("rand%0d", n), mPc, mCe, mHolding ? mHeld : rData);
         modelStep(rRst, rStall, rBr, rAddr, rData);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
